// File: rtl/reservation_station_pkg.sv
// Shared opcode encodings and default sizing for the reservation station slice.
package reservation_station_pkg;

  localparam int unsigned RS_SIZE_DEF = 8;
  localparam int unsigned ROB_W_DEF   = 4;
  localparam int unsigned OPC_W       = 6;
  localparam int unsigned XLEN        = 32;

  localparam logic [OPC_W-1:0] OP_NOP = 6'd0;
  localparam logic [OPC_W-1:0] OP_ADD = 6'd1;
  localparam logic [OPC_W-1:0] OP_SUB = 6'd2;
  localparam logic [OPC_W-1:0] OP_AND = 6'd3;
  localparam logic [OPC_W-1:0] OP_OR  = 6'd4;
  localparam logic [OPC_W-1:0] OP_XOR = 6'd5;
  localparam logic [OPC_W-1:0] OP_SLL = 6'd6;
  localparam logic [OPC_W-1:0] OP_SRL = 6'd7;

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-index priority encoder: one-hot grant, binary index and a found flag.
module rs_prio_enc #(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found_o  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_i[i] && !found_o) begin
        onehot_o[i] = 1'b1;
        idx_o       = IW'(i);
        found_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: issue into lowest free slot, CDB wakeup with issue-time
// bypass, and registered dispatch of the lowest-index ready entry.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int unsigned RS_SIZE = RS_SIZE_DEF,
  parameter int unsigned ROB_W   = ROB_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clr,
  input  logic             issue_valid,
  input  logic [OPC_W-1:0] issue_opcode,
  input  logic [XLEN-1:0]  issue_Vj,
  input  logic [ROB_W-1:0] issue_Qj,
  input  logic             issue_Qj_busy,
  input  logic [XLEN-1:0]  issue_Vk,
  input  logic [ROB_W-1:0] issue_Qk,
  input  logic             issue_Qk_busy,
  input  logic [XLEN-1:0]  issue_imm,
  input  logic [XLEN-1:0]  issue_pc,
  input  logic [ROB_W-1:0] issue_rob,
  output logic             rs_full,
  input  logic             cdb_valid,
  input  logic [ROB_W-1:0] cdb_rob,
  input  logic [XLEN-1:0]  cdb_value,
  output logic             RS_sgn,
  output logic [OPC_W-1:0] RS_opcode,
  output logic [XLEN-1:0]  RS_lhs,
  output logic [XLEN-1:0]  RS_rhs,
  output logic [XLEN-1:0]  RS_imm,
  output logic [XLEN-1:0]  RS_pc,
  output logic [ROB_W-1:0] ROB_entry
);

  localparam int unsigned IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [RS_SIZE-1:0] qj_busy_q, qj_busy_d;
  logic [RS_SIZE-1:0] qk_busy_q, qk_busy_d;
  logic [OPC_W-1:0]   opcode_q [RS_SIZE];
  logic [XLEN-1:0]    vj_q     [RS_SIZE];
  logic [XLEN-1:0]    vk_q     [RS_SIZE];
  logic [XLEN-1:0]    vj_d     [RS_SIZE];
  logic [XLEN-1:0]    vk_d     [RS_SIZE];
  logic [XLEN-1:0]    imm_q    [RS_SIZE];
  logic [XLEN-1:0]    pc_q     [RS_SIZE];
  logic [ROB_W-1:0]   qj_q     [RS_SIZE];
  logic [ROB_W-1:0]   qk_q     [RS_SIZE];
  logic [ROB_W-1:0]   rob_q    [RS_SIZE];

  logic [RS_SIZE-1:0] free_oh, rdy_oh, ready_vec, issue_we, wake_j, wake_k;
  logic               free_found, rdy_found, issue_fire, byp_j, byp_k;
  logic [IW-1:0]      rdy_idx, free_idx_unused;

  assign rs_full    = &busy_q;
  assign ready_vec  = busy_q & ~qj_busy_q & ~qk_busy_q;
  assign issue_fire = rdy && !clr && issue_valid && free_found;
  assign issue_we   = {RS_SIZE{issue_fire}} & free_oh;
  assign byp_j      = issue_Qj_busy && cdb_valid && (cdb_rob == issue_Qj);
  assign byp_k      = issue_Qk_busy && cdb_valid && (cdb_rob == issue_Qk);

  rs_prio_enc #(.N(RS_SIZE), .IW(IW)) u_free_sel (
    .req_i    (~busy_q),
    .onehot_o (free_oh),
    .idx_o    (free_idx_unused),
    .found_o  (free_found)
  );

  rs_prio_enc #(.N(RS_SIZE), .IW(IW)) u_ready_sel (
    .req_i    (ready_vec),
    .onehot_o (rdy_oh),
    .idx_o    (rdy_idx),
    .found_o  (rdy_found)
  );

  // Free and ready selections come from disjoint busy states, so an entry can
  // never be written by issue and released by dispatch on the same edge.
  always_comb begin
    busy_d    = busy_q;
    qj_busy_d = qj_busy_q;
    qk_busy_d = qk_busy_q;
    wake_j    = '0;
    wake_k    = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      wake_j[i]    = busy_q[i] && qj_busy_q[i] && cdb_valid && (qj_q[i] == cdb_rob);
      wake_k[i]    = busy_q[i] && qk_busy_q[i] && cdb_valid && (qk_q[i] == cdb_rob);
      busy_d[i]    = busy_q[i] & ~rdy_oh[i];
      qj_busy_d[i] = qj_busy_q[i] & ~wake_j[i];
      qk_busy_d[i] = qk_busy_q[i] & ~wake_k[i];
      vj_d[i]      = wake_j[i] ? cdb_value : vj_q[i];
      vk_d[i]      = wake_k[i] ? cdb_value : vk_q[i];
      if (issue_we[i]) begin
        busy_d[i]    = 1'b1;
        qj_busy_d[i] = issue_Qj_busy & ~byp_j;
        qk_busy_d[i] = issue_Qk_busy & ~byp_k;
        vj_d[i]      = byp_j ? cdb_value : issue_Vj;
        vk_d[i]      = byp_k ? cdb_value : issue_Vk;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q    <= '0;
      qj_busy_q <= '0;
      qk_busy_q <= '0;
      RS_sgn    <= 1'b0;
      RS_opcode <= '0;
      RS_lhs    <= '0;
      RS_rhs    <= '0;
      RS_imm    <= '0;
      RS_pc     <= '0;
      ROB_entry <= '0;
    end else if (clr) begin
      busy_q <= '0;
      RS_sgn <= 1'b0;
    end else if (rdy) begin
      busy_q    <= busy_d;
      qj_busy_q <= qj_busy_d;
      qk_busy_q <= qk_busy_d;
      RS_sgn    <= rdy_found;
      if (rdy_found) begin
        RS_opcode <= opcode_q[rdy_idx];
        RS_lhs    <= vj_q[rdy_idx];
        RS_rhs    <= vk_q[rdy_idx];
        RS_imm    <= imm_q[rdy_idx];
        RS_pc     <= pc_q[rdy_idx];
        ROB_entry <= rob_q[rdy_idx];
      end
    end
  end

  // Entry payload is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    if (rdy && !clr) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        vj_q[i] <= vj_d[i];
        vk_q[i] <= vk_d[i];
        if (issue_we[i]) begin
          opcode_q[i] <= issue_opcode;
          qj_q[i]     <= issue_Qj;
          qk_q[i]     <= issue_Qk;
          imm_q[i]    <= issue_imm;
          pc_q[i]     <= issue_pc;
          rob_q[i]    <= issue_rob;
        end
      end
    end
  end

endmodule
